// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI responder: FSM states,
// command-byte field positions and the SPI byte width.
package hkspi_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_WR     = 7;
  localparam int CMD_RD     = 6;
  localparam int CMD_CNT_HI = 5;
  localparam int CMD_CNT_LO = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  function automatic logic [2:0] cmd_count(input logic [BYTE_W-1:0] cmd);
    return cmd[CMD_CNT_HI:CMD_CNT_LO];
  endfunction

endpackage

// File: rtl/hkspi_sync.sv
// Pad-side synchronizer for SCK/CSB/SDI with SCK edge detection; SDI is kept
// at the same pipeline depth as SCK so the detected rise samples aligned data.
module hkspi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic sck,
  input  logic csb,
  input  logic sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_s,
  output logic sdi_s
);

  logic [SYNC_STAGES-1:0] sck_p0;
  logic [SYNC_STAGES-1:0] csb_p0;
  logic [SYNC_STAGES-1:0] sdi_p0;
  logic                   sck_p1;

  // CSB resets deasserted so busy reads 0 during and right after reset
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_p0 <= '0;
      csb_p0 <= '1;
      sdi_p0 <= '0;
      sck_p1 <= 1'b0;
    end else begin
      sck_p0 <= {sck_p0[SYNC_STAGES-2:0], sck};
      csb_p0 <= {csb_p0[SYNC_STAGES-2:0], csb};
      sdi_p0 <= {sdi_p0[SYNC_STAGES-2:0], sdi};
      sck_p1 <= sck_p0[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_p0[SYNC_STAGES-1] & ~sck_p1;
  assign sck_fall = ~sck_p0[SYNC_STAGES-1] & sck_p1;
  assign csb_s    = csb_p0[SYNC_STAGES-1];
  assign sdi_s    = sdi_p0[SYNC_STAGES-1];

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder: decodes command/address/data bytes from an
// oversampled mode-0 SPI slave port and drives an auto-incrementing register
// port. Optional HKSPI_SDO_OEB_EN adds an active-low SDO output enable.
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
`ifdef HKSPI_SDO_OEB_EN
  output logic              sdo_oeb,
`endif
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);

  logic sck_rise;
  logic sck_fall_unused;
  logic csb_s;
  logic sdi_s;

  hkspi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .resetb  (resetb),
    .sck     (sck),
    .csb     (csb),
    .sdi     (sdi),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall_unused),
    .csb_s   (csb_s),
    .sdi_s   (sdi_s)
  );

  state_t state;
  state_t state_nxt;

  logic [1:0]        flush_cnt;
  logic              csb_p1;
  logic              csb_fall;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] rx_sr;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] tx_sr;
  logic              cmd_wr;
  logic              cmd_rd;
  logic              cnt_mode;
  logic [2:0]        cnt_left;
  logic              inc_pend;
  logic              byte_done;
  logic              last_byte;
  logic              rd_window;

  // The CSB edge history only starts once the synchronizer holds real pad
  // samples, so a CSB already low at reset release is not taken as a fall.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      flush_cnt <= 2'd0;
      csb_p1    <= 1'b0;
    end else begin
      if (flush_cnt != 2'(SYNC_STAGES)) flush_cnt <= flush_cnt + 2'd1;
      csb_p1 <= (flush_cnt == 2'(SYNC_STAGES)) ? csb_s : 1'b0;
    end
  end

  assign csb_fall  = csb_p1 & ~csb_s;
  assign rx_byte   = {rx_sr, sdi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state inside {CMD, ADDR, DATA});
  assign last_byte = cnt_mode && (cnt_left == 3'd1);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (csb_fall) state_nxt = CMD;
      CMD: begin
        if (csb_s) state_nxt = IDLE;
        else if (byte_done)
          state_nxt = (rx_byte[CMD_WR] || rx_byte[CMD_RD]) ? ADDR : IGNORE;
      end
      ADDR: begin
        if (csb_s)          state_nxt = IDLE;
        else if (byte_done) state_nxt = DATA;
      end
      DATA: begin
        if (csb_s)                       state_nxt = IDLE;
        else if (byte_done && last_byte) state_nxt = IGNORE;
      end
      IGNORE:  if (csb_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_window = (state == DATA) && cmd_rd;
    sdo       = rd_window & tx_sr[BYTE_W-1];
    busy      = ~csb_s;
  end

`ifdef HKSPI_SDO_OEB_EN
  assign sdo_oeb = ~rd_window;
`endif

  // A write byte strobes at address N first; the increment and the read
  // prefetch of N+1 follow one clock later. Read-only bytes advance at once.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      cnt_mode  <= 1'b0;
      cnt_left  <= 3'd0;
      inc_pend  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      inc_pend <= 1'b0;

      if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sr   <= rx_byte[BYTE_W-2:0];
      end

      if (state == CMD && byte_done) begin
        cmd_wr   <= rx_byte[CMD_WR];
        cmd_rd   <= rx_byte[CMD_RD];
        cnt_left <= cmd_count(rx_byte);
        cnt_mode <= |cmd_count(rx_byte);
      end

      if (state == ADDR && byte_done) begin
        reg_addr <= ADDR_W'(rx_byte);
        reg_re   <= cmd_rd;
      end

      if (state == DATA && byte_done) begin
        if (cnt_mode) cnt_left <= cnt_left - 3'd1;
        if (cmd_wr) begin
          reg_we    <= 1'b1;
          reg_wdata <= rx_byte;
          inc_pend  <= 1'b1;
        end else begin
          reg_addr <= reg_addr + ADDR_W'(1);
          reg_re   <= cmd_rd && !last_byte;
        end
      end

      if (inc_pend) begin
        reg_addr <= reg_addr + ADDR_W'(1);
        reg_re   <= cmd_rd && (state == DATA);
      end

      if (reg_re)
        tx_sr <= reg_rdata;
      else if (state == DATA && sck_rise)
        tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_hkspi_responder.sv
// Scoreboard bench for hkspi_responder: directed SPI transactions push the
// expected strobes and SDO bytes; independent monitors pop and compare.
module tb_hkspi_responder;

  localparam int HALF = 6;

  logic       clock  = 1'b0;
  logic       resetb = 1'b0;
  logic       sck    = 1'b0;
  logic       csb    = 1'b1;
  logic       sdi    = 1'b0;
  logic       sdo;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
`ifdef HKSPI_SDO_OEB_EN
  logic       sdo_oeb;
`endif

  logic [7:0]  bank [256];
  logic [7:0]  exp_sdo_q [$];
  logic [15:0] exp_we_q [$];
  logic [7:0]  exp_re_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hkspi_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .resetb   (resetb),
    .sck      (sck),
    .csb      (csb),
    .sdi      (sdi),
    .sdo      (sdo),
`ifdef HKSPI_SDO_OEB_EN
    .sdo_oeb  (sdo_oeb),
`endif
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0: return 8'h00;
      1: return 8'h04;
      2: return 8'h56;
      3: return 8'h11;
      default: return 8'((i * 37 + 5) & 255);
    endcase
  endfunction

  assign reg_rdata = bank[reg_addr];

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (reg_we) bank[reg_addr] <= reg_wdata;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event %0h expected none", name, act);
  endtask

  // Strobe monitor
  always @(negedge clock) begin : strobe_mon
    logic [15:0] e;
    if (resetb) begin
      if (reg_we) begin
        if (exp_we_q.size() > 0) begin
          e = exp_we_q.pop_front();
          chk("we_addr", int'(reg_addr), int'(e[15:8]));
          chk("we_data", int'(reg_wdata), int'(e[7:0]));
        end else unexpected("we", int'(reg_addr));
      end
      if (reg_re) begin
        if (exp_re_q.size() > 0) begin
          e = {8'h00, exp_re_q.pop_front()};
          chk("re_addr", int'(reg_addr), int'(e[7:0]));
        end else unexpected("re", int'(reg_addr));
      end
    end
  end

  // SDO monitor: master-side view, sampled on each SCK rise
  int         m_bits  = 0;
  int         m_bytes = 0;
  logic [7:0] m_sh    = 8'h00;
  always @(posedge sck or posedge csb or negedge resetb) begin
    if (csb || !resetb) begin
      m_bits  = 0;
      m_bytes = 0;
    end else begin
      m_sh = {m_sh[6:0], sdo};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_bytes >= 2) begin
          if (exp_sdo_q.size() > 0) chk("sdo_byte", int'(m_sh), int'(exp_sdo_q.pop_front()));
          else unexpected("sdo_byte", int'(m_sh));
        end
        m_bytes++;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = b[i];
      repeat (HALF) @(negedge clock);
      sck = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clock);
    csb = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clock);
    csb = 1'b1;
    repeat (4 * HALF) @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sdo"}, int'(sdo), 0);
    chk({tag, "_addr"}, int'(reg_addr), 0);
    chk({tag, "_wdata"}, int'(reg_wdata), 0);
    chk({tag, "_we"}, int'(reg_we), 0);
    chk({tag, "_re"}, int'(reg_re), 0);
    chk({tag, "_busy"}, int'(busy), 0);
`ifdef HKSPI_SDO_OEB_EN
    chk({tag, "_oeb"}, int'(sdo_oeb), 1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clock);
    chk_reset_outputs("rst");
    resetb = 1'b1;
    repeat (5) @(negedge clock);

    // Read ID: reg3 = 0x11, then the prefetch of 0x04
    exp_re_q.push_back(8'h03);
    exp_re_q.push_back(8'h04);
    exp_sdo_q.push_back(8'h11);
    cs_low();
    chk("busy_low", int'(busy), 1);
    spi_bits(8'h40, 8); spi_bits(8'h03, 8); spi_bits(8'h00, 8);
    cs_high();
    chk("busy_idle", int'(busy), 0);

    // Stream read of 19 bytes from 0x00
    for (int i = 0; i <= 19; i++) exp_re_q.push_back(8'(i));
    for (int i = 0; i < 19; i++) exp_sdo_q.push_back(init_val(i));
    cs_low();
    spi_bits(8'h40, 8); spi_bits(8'h00, 8);
    for (int i = 0; i < 19; i++) spi_bits(8'h00, 8);
    cs_high();

    // Count mode, count = 1
    exp_re_q.push_back(8'h10);
    exp_sdo_q.push_back(init_val(16));
    exp_sdo_q.push_back(8'h00);
    exp_sdo_q.push_back(8'h00);
    cs_low();
    spi_bits(8'h48, 8); spi_bits(8'h10, 8);
    for (int i = 0; i < 3; i++) spi_bits(8'h00, 8);
    cs_high();

    // Single write
    exp_we_q.push_back(16'h0B01);
    exp_sdo_q.push_back(8'h00);
    cs_low();
    spi_bits(8'h80, 8); spi_bits(8'h0B, 8); spi_bits(8'h01, 8);
    cs_high();
    chk("bank_0b", int'(bank[8'h0B]), 8'h01);

    // Write across the address wrap, then abort mid-byte
    exp_we_q.push_back(16'hFFAA);
    exp_we_q.push_back(16'h0055);
    exp_sdo_q.push_back(8'h00);
    exp_sdo_q.push_back(8'h00);
    cs_low();
    spi_bits(8'h80, 8); spi_bits(8'hFF, 8); spi_bits(8'hAA, 8); spi_bits(8'h55, 8);
    spi_bits(8'hC3, 4);
    csb = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    repeat (4 * HALF) @(negedge clock);
    chk("bank_ff", int'(bank[8'hFF]), 8'hAA);
    chk("bank_00", int'(bank[8'h00]), 8'h55);
    chk("wrap_addr", int'(reg_addr), 8'h01);

    // Reset during the address byte
    cs_low();
    spi_bits(8'h40, 8); spi_bits(8'h03, 4);
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("midrst");
    resetb = 1'b1;
    // CSB still low from before the reset: no new transaction may start
    repeat (HALF) @(negedge clock);
    chk("stuck_busy", int'(busy), 1);
    spi_bits(8'h40, 8); spi_bits(8'h03, 8);
    chk("stuck_sdo", int'(sdo), 0);
    cs_high();

    exp_re_q.push_back(8'h03);
    exp_re_q.push_back(8'h04);
    exp_sdo_q.push_back(8'h11);
    cs_low();
    spi_bits(8'h40, 8); spi_bits(8'h03, 8); spi_bits(8'h00, 8);
    cs_high();

    repeat (10) @(negedge clock);
    chk("we_left", exp_we_q.size(), 0);
    chk("re_left", exp_re_q.size(), 0);
    chk("sdo_left", exp_sdo_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
